// File: rtl/gray_to_binary_tracker.sv
// Gray-coded counter receiver: two-stage Gray-to-binary decode and a step monitor.
// It flags counter wrap and illegal jumps, and keeps a saturating count of illegal jumps.
module gray_to_binary_tracker #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     binary_out,
    output logic                 wrap,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        SEED  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state, state_nxt;

    logic [WIDTH-1:0] gray_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] bin_p1;
    logic [WIDTH-1:0] ref_p2;
    logic [WIDTH-1:0] ref_inc;
    logic             is_hold;
    logic             is_inc;
    logic             wrap_nxt;
    logic             err_nxt;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    // Stage 1: capture the incoming Gray sample
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
        end
        if (in_valid) begin
            gray_p1 <= gray_in;
        end
    end

    // Decode plus step classification against the stored reference
    always_comb begin
        state_nxt = state;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        bin_p1    = gray2bin(gray_p1);
        ref_inc   = ref_p2 + WIDTH'(1);
        is_hold   = (bin_p1 == ref_p2);
        is_inc    = (bin_p1 == ref_inc);
        if (vld_p1) begin
            case (state)
                SEED: begin
                    state_nxt = TRACK;
                end
                TRACK: begin
                    wrap_nxt = is_inc && (&ref_p2);
                    err_nxt  = !(is_hold || is_inc);
                end
                default: begin
                    state_nxt = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    assign locked = (state == TRACK);

    // Stage 2: registered decode result and flags; illegal steps also resync the reference
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            binary_out <= '0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            ref_p2     <= '0;
            err_count  <= '0;
        end else begin
            out_valid <= vld_p1;
            wrap      <= wrap_nxt;
            step_err  <= err_nxt;
            if (vld_p1) begin
                binary_out <= bin_p1;
                ref_p2     <= bin_p1;
                if (err_nxt) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Bench for gray_to_binary_tracker: a table of vectors feeds a latency-tagged scoreboard.
// Two instances run side by side: default counter width and a 2-bit counter for saturation.
module tb_gray_to_binary_tracker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] gray_in;

    logic         out_valid_a, wrap_a, step_err_a, locked_a;
    logic [W-1:0] binary_out_a;
    logic [7:0]   err_count_a;
    logic         out_valid_b, wrap_b, step_err_b, locked_b;
    logic [W-1:0] binary_out_b;
    logic [1:0]   err_count_b;

    always #5 clk = ~clk;

    gray_to_binary_tracker #(.WIDTH(W), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(out_valid_a), .binary_out(binary_out_a), .wrap(wrap_a),
        .step_err(step_err_a), .locked(locked_a), .err_count(err_count_a)
    );

    gray_to_binary_tracker #(.WIDTH(W), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in),
        .out_valid(out_valid_b), .binary_out(binary_out_b), .wrap(wrap_b),
        .step_err(step_err_b), .locked(locked_b), .err_count(err_count_b)
    );

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] g;
        logic [W-1:0] eb;
        logic         ew;
        logic         ee;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] b;
        logic         w;
        logic         e;
        logic [7:0]   ca;
        logic [1:0]   cb;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];
    vec_t tbl[$];

    // Model state as of the most recently driven sample
    logic       m_lk;
    logic [7:0] m_ca;
    logic [1:0] m_cb;
    // Expected values currently visible on the DUT outputs
    logic [W-1:0] vis_b;
    logic         vis_lk;
    logic [7:0]   vis_ca;
    logic [1:0]   vis_cb;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] g,
                                input logic [W-1:0] eb, input logic ew, input logic ee);
        vec_t t;
        t.rst = r; t.vld = v; t.g = g; t.eb = eb; t.ew = ew; t.ee = ee;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        logic ev, ew, ee;
        @(negedge clk);
        ev = 1'b0; ew = 1'b0; ee = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = 1'b1; ew = e.w; ee = e.e;
            vis_b = e.b; vis_lk = 1'b1; vis_ca = e.ca; vis_cb = e.cb;
        end
        chk("out_valid_a",  32'(out_valid_a),  32'(ev));
        chk("binary_out_a", 32'(binary_out_a), 32'(vis_b));
        chk("wrap_a",       32'(wrap_a),       32'(ew));
        chk("step_err_a",   32'(step_err_a),   32'(ee));
        chk("locked_a",     32'(locked_a),     32'(vis_lk));
        chk("err_count_a",  32'(err_count_a),  32'(vis_ca));
        chk("out_valid_b",  32'(out_valid_b),  32'(ev));
        chk("binary_out_b", 32'(binary_out_b), 32'(vis_b));
        chk("step_err_b",   32'(step_err_b),   32'(ee));
        chk("locked_b",     32'(locked_b),     32'(vis_lk));
        chk("err_count_b",  32'(err_count_b),  32'(vis_cb));

        rst      = v.rst;
        in_valid = v.vld;
        gray_in  = v.g;
        if (v.rst) begin
            q.delete();
            m_lk = 1'b0; m_ca = '0; m_cb = '0;
            vis_b = '0; vis_lk = 1'b0; vis_ca = '0; vis_cb = '0;
        end else if (v.vld) begin
            if (!m_lk) begin
                m_lk = 1'b1;
            end else if (v.ee) begin
                if (m_ca != 8'hFF) m_ca = m_ca + 8'd1;
                if (m_cb != 2'd3)  m_cb = m_cb + 2'd1;
            end
            e.due = cyc + 2; e.b = v.eb; e.w = v.ew; e.e = v.ee; e.ca = m_ca; e.cb = m_cb;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(1'b0, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; gray_in = '0;
        m_lk = 1'b0; m_ca = '0; m_cb = '0;
        vis_b = '0; vis_lk = 1'b0; vis_ca = '0; vis_cb = '0;
        @(posedge clk);

        // Reset, idle, seed at 7, then legal sweep 8,8,9..15,0(wrap),1
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 4'd7,  0, 0));
        tbl.push_back(mk(0, 1, 4'b1100, 4'd8,  0, 0));
        tbl.push_back(mk(0, 1, 4'b1100, 4'd8,  0, 0));
        tbl.push_back(mk(0, 1, 4'b1101, 4'd9,  0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 4'd10, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1110, 4'd11, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 4'd0,  0, 0));
        tbl.push_back(mk(0, 1, 4'b1010, 4'd12, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1011, 4'd13, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1001, 4'd14, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1000, 4'd15, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 4'd0,  1, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 4'd1,  0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0));
        // Illegal jump 5 -> 3, then 4 is legal against the resynced reference
        tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0111, 4'd5, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0010, 4'd3, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0110, 4'd4, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Saturation: seed 0, then five alternating 2/0 jumps with a gap in between
        step(mk(1, 0, 4'b0000, 0, 0, 0));
        step(mk(0, 1, 4'b0000, 4'd0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) step(mk(0, 1, 4'b0011, 4'd2, 0, 1));
            else            step(mk(0, 1, 4'b0000, 4'd0, 0, 1));
            if (i == 2) idle(2);
        end
        idle(3);

        // Reset mid-pipeline: both in-flight samples vanish, next one re-seeds
        step(mk(0, 1, 4'b0001, 4'd1, 0, 0));
        step(mk(1, 1, 4'b0011, 4'd2, 0, 0));
        idle(3);
        step(mk(0, 1, 4'b0101, 4'd6, 0, 0));
        step(mk(0, 1, 4'b0100, 4'd7, 0, 0));
        idle(4);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
